// File: rtl/alu_op_sequencer.sv
// Control FSM sequencing one reg-to-reg ALU instruction over the shared bus.
// Ports: Clock/clear, start+opcode/ra/rb/rc request; busy/done, bus strobes out.
module alu_op_sequencer #(
  parameter int NREGS = 16,
  parameter logic [4:0] OP_MUL = 5'b01111,
  parameter logic [4:0] OP_DIV = 5'b10000,
  parameter logic [4:0] OP_NEG = 5'b10001,
  parameter logic [4:0] OP_NOT = 5'b10010
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic             busy,
  output logic             done,
  output logic [4:0]       alu_op,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic             Yin,
  output logic             Zhighin,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    Y_LD  = 3'd1,
    Z_LD  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  state_t     state;
  logic [4:0] op_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic [3:0] rc_q;

  logic unary_in;
  logic wide_q;

  assign unary_in = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign wide_q   = (op_q == OP_MUL) || (op_q == OP_DIV);

  // Outputs are registered: each arm loads the strobes of the state
  // being entered, so they line up with the state register.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_op   <= '0;
      Rout     <= '0;
      Rin      <= '0;
      Yin      <= 1'b0;
      Zhighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
    end else begin
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_op   <= '0;
      Rout     <= '0;
      Rin      <= '0;
      Yin      <= 1'b0;
      Zhighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= opcode;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            busy <= 1'b1;
            // Entry strobes come from the live inputs being captured.
            if (unary_in) begin
              state   <= Z_LD;
              Rout    <= ONE << rc;
              alu_op  <= opcode;
              Zhighin <= 1'b1;
              Zlowin  <= 1'b1;
            end else begin
              state <= Y_LD;
              Rout  <= ONE << rb;
              Yin   <= 1'b1;
            end
          end
        end
        Y_LD: begin
          state   <= Z_LD;
          busy    <= 1'b1;
          Rout    <= ONE << rc_q;
          alu_op  <= op_q;
          Zhighin <= 1'b1;
          Zlowin  <= 1'b1;
        end
        Z_LD: begin
          state   <= WB_LO;
          busy    <= 1'b1;
          Zlowout <= 1'b1;
          if (wide_q) LOin <= 1'b1;
          else        Rin  <= ONE << ra_q;
        end
        WB_LO: begin
          busy <= 1'b1;
          if (wide_q) begin
            state    <= WB_HI;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        WB_HI: begin
          state <= DONE;
          busy  <= 1'b1;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: per-cycle expected output vectors
// are queued when a request is driven and popped one per clock.
module tb_alu_op_sequencer;

  localparam logic [4:0] MUL = 5'b01111;
  localparam logic [4:0] DIV = 5'b10000;
  localparam logic [4:0] NEG = 5'b10001;
  localparam logic [4:0] NOT = 5'b10010;

  localparam logic [6:0] S_Y    = 7'b1000000;
  localparam logic [6:0] S_Z    = 7'b0110000;
  localparam logic [6:0] S_LO   = 7'b0001000;
  localparam logic [6:0] S_LOW  = 7'b0001010;
  localparam logic [6:0] S_HI   = 7'b0000101;
  localparam logic [45:0] ZERO  = '0;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done;
  logic [4:0]  alu_op;
  logic [15:0] Rout, Rin;
  logic        Yin, Zhighin, Zlowin, Zlowout, Zhighout, LOin, HIin;

  int checks = 0;
  int errors = 0;
  logic [45:0] q[$];

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done),
    .alu_op(alu_op), .Rout(Rout), .Rin(Rin), .Yin(Yin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin)
  );

  always #5 Clock = ~Clock;

  wire [45:0] obs = {busy, done, alu_op, Rout, Rin,
                     Yin, Zhighin, Zlowin, Zlowout, Zhighout, LOin, HIin};

  function automatic logic [45:0] ev(input logic bz, input logic dn,
                                     input logic [4:0] op,
                                     input logic [15:0] ro,
                                     input logic [15:0] ri,
                                     input logic [6:0] st);
    return {bz, dn, op, ro, ri, st};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [45:0] o,
                     input logic [45:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic chk_excl(input string tag);
    int drv;
    drv = int'(|Rout) + int'(Zlowout) + int'(Zhighout);
    checks++;
    assert ($countones(Rout) <= 1 && $countones(Rin) <= 1 && drv <= 1)
    else begin
      errors++;
      $error("FAIL %s excl Rout=%h Rin=%h drv=%0d exp=onehot/1", tag,
             Rout, Rin, drv);
    end
  endtask

  // Expected per-cycle outputs for one request, then its trailing IDLE.
  task automatic push_op(input logic [4:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c);
    logic wide, un;
    wide = (op == MUL) || (op == DIV);
    un   = (op == NEG) || (op == NOT);
    if (!un) q.push_back(ev(1, 0, 5'd0, oh(b), 16'd0, S_Y));
    q.push_back(ev(1, 0, op, oh(c), 16'd0, S_Z));
    if (wide) begin
      q.push_back(ev(1, 0, 5'd0, 16'd0, 16'd0, S_LOW));
      q.push_back(ev(1, 0, 5'd0, 16'd0, 16'd0, S_HI));
    end else begin
      q.push_back(ev(1, 0, 5'd0, 16'd0, oh(a), S_LO));
    end
    q.push_back(ev(1, 1, 5'd0, 16'd0, 16'd0, 7'd0));
    q.push_back(ZERO);
  endtask

  task automatic tick(input string tag);
    logic [45:0] e;
    @(posedge Clock);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s queue empty obs=%h exp=entry", tag, obs);
    end else begin
      e = q.pop_front();
      chk(tag, obs, e);
    end
    chk_excl(tag);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      tick(tag);
      guard++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout left=%0d exp=0", tag, q.size());
    end
  endtask

  task automatic req(input logic [4:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c);
    opcode = op;
    ra = a;
    rb = b;
    rc = c;
    start = 1'b1;
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    opcode = '0;
    ra = '0;
    rb = '0;
    rc = '0;
    #1;
    chk("reset", obs, ZERO);

    // start while clear is high must be ignored
    req(5'b00001, 4'd1, 4'd2, 4'd3);
    q.push_back(ZERO);
    tick("clr_start0");
    q.push_back(ZERO);
    tick("clr_start1");
    start = 1'b0;
    clear = 1'b0;
    q.push_back(ZERO);
    tick("idle");

    // binary op
    req(5'b00101, 4'd1, 4'd2, 4'd3);
    push_op(5'b00101, 4'd1, 4'd2, 4'd3);
    tick("bin_y");
    start = 1'b0;
    opcode = 5'b11111;
    ra = 4'd15;
    rb = 4'd15;
    rc = 4'd15;
    drain("bin");

    // MUL writes LO/HI, no Rin
    req(MUL, 4'd7, 4'd4, 4'd5);
    push_op(MUL, 4'd7, 4'd4, 4'd5);
    tick("mul_y");
    start = 1'b0;
    drain("mul");

    // DIV, shared indices
    req(DIV, 4'd0, 4'd0, 4'd0);
    push_op(DIV, 4'd0, 4'd0, 4'd0);
    tick("div_y");
    start = 1'b0;
    drain("div");

    // unary ops skip Y_LD
    req(NOT, 4'd9, 4'd1, 4'd9);
    push_op(NOT, 4'd9, 4'd1, 4'd9);
    tick("not_z");
    start = 1'b0;
    drain("not");

    req(NEG, 4'd0, 4'd6, 4'd15);
    push_op(NEG, 4'd0, 4'd6, 4'd15);
    tick("neg_z");
    start = 1'b0;
    drain("neg");

    // start during WB_LO is ignored
    req(5'b00001, 4'd3, 4'd4, 4'd5);
    push_op(5'b00001, 4'd3, 4'd4, 4'd5);
    q.push_back(ZERO);
    tick("ign_y");
    start = 1'b0;
    tick("ign_z");
    tick("ign_lo");
    req(5'b00010, 4'd8, 4'd9, 4'd10);
    tick("ign_done");
    start = 1'b0;
    drain("ign");

    // start held high: two ops, one IDLE cycle apart
    req(5'b00011, 4'd1, 4'd2, 4'd3);
    push_op(5'b00011, 4'd1, 4'd2, 4'd3);
    q.pop_back();
    q.push_back(ZERO);
    push_op(5'b00100, 4'd6, 4'd7, 4'd8);
    tick("b2b_a_y");
    opcode = 5'b00100;
    ra = 4'd6;
    rb = 4'd7;
    rc = 4'd8;
    tick("b2b_a_z");
    tick("b2b_a_lo");
    tick("b2b_a_done");
    tick("b2b_idle");
    tick("b2b_b_y");
    start = 1'b0;
    drain("b2b");

    // clear mid-sequence in Z_LD
    req(5'b00011, 4'd2, 4'd3, 4'd4);
    push_op(5'b00011, 4'd2, 4'd3, 4'd4);
    tick("clr_y");
    start = 1'b0;
    tick("clr_z");
    #2;
    clear = 1'b1;
    #1;
    chk("clr_async", obs, ZERO);
    q.delete();
    q.push_back(ZERO);
    tick("clr_hold");
    clear = 1'b0;
    req(5'b00011, 4'd1, 4'd2, 4'd3);
    push_op(5'b00011, 4'd1, 4'd2, 4'd3);
    tick("clr_restart_y");
    start = 1'b0;
    drain("clr_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog obs=%h exp=finish", obs);
    $fatal(1, "timeout");
  end

endmodule
